// File: rtl/ddr2_pkg.sv
// Shared types and helpers for the DDR2 multi-host front end.
package ddr2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_e;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr2_port_arbiter_rr_arbiter.sv
// Round-robin priority select: the first requester at or after ptr wins.
module rr_arbiter
    import ddr2_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic found_s;
    int   pos_s;

    // Scan ptr, ptr+1, ... with wrap; ptr is always below NUM_PORTS.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        pos_s     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pos_s = int'(ptr) + i;
            if (pos_s >= NUM_PORTS) begin
                pos_s = pos_s - NUM_PORTS;
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[IDX_W'(pos_s)]) begin
                found_s                = 1'b1;
                grant[IDX_W'(pos_s)]   = 1'b1;
                grant_idx              = IDX_W'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Round-robin host front end serialising single-beat byte requests onto the
// DDR2 controller's CEb/WEb SRAM-style interface, with ack timeout reporting.
module ddr2_port_arbiter
    import ddr2_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CE_PULSE    = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    input  logic                        ctl_init_done,
    input  logic                        ctl_ready,
    output logic                        ctl_ceb,
    output logic                        ctl_web,
    output logic [ADDR_W-1:0]           ctl_addr,
    output logic [DATA_W-1:0]           ctl_wdata,
    input  logic [DATA_W-1:0]           ctl_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
    localparam int CE_W  = clog2(CE_PULSE + 1);
    localparam int TO_W  = clog2(ACK_TIMEOUT + 1);
    localparam logic [CE_W-1:0]  CE_LAST  = CE_W'(CE_PULSE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

    arb_state_e           state_r, state_s;
    logic [IDX_W-1:0]     ptr_r, gnt_idx_r, arb_idx_s;
    logic [NUM_PORTS-1:0] arb_gnt_s;
    logic                 we_r, we_s, busy_seen_r, grant_s, timeout_s;
    logic [CE_W-1:0]      ce_cnt_r;
    logic [TO_W-1:0]      to_cnt_r;
    logic [NUM_PORTS-1:0] req_ready_r, rsp_valid_r;
    logic [DATA_W-1:0]    rsp_rdata_r, ctl_wdata_r;
    logic                 rsp_err_r, ctl_ceb_r, ctl_web_r;
    logic [ADDR_W-1:0]    ctl_addr_r;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (arb_gnt_s),
        .grant_idx (arb_idx_s)
    );

    assign grant_s = (state_r == IDLE) && ctl_init_done && ctl_ready && (|req_valid);
    assign we_s    = grant_s ? req_we[arb_idx_s] : we_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a busy seen during the CE pulse counts as the ack.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) state_s = ISSUE;
                else         state_s = IDLE;
            end
            ISSUE: begin
                if (ce_cnt_r == CE_LAST) state_s = WAIT_BUSY;
                else                     state_s = ISSUE;
            end
            WAIT_BUSY: begin
                if (!ctl_ready || busy_seen_r) begin
                    state_s = WAIT_DONE;
                end else if (to_cnt_r == TO_LAST) begin
                    state_s   = RESP;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (ctl_ready) state_s = RESP;
                else           state_s = WAIT_DONE;
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Transaction bookkeeping: latched winner, phase counters and rr pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r       <= '0;
            gnt_idx_r   <= '0;
            we_r        <= 1'b0;
            busy_seen_r <= 1'b0;
            ce_cnt_r    <= '0;
            to_cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        we_r      <= req_we[arb_idx_s];
                        gnt_idx_r <= arb_idx_s;
                    end
                    ce_cnt_r    <= '0;
                    to_cnt_r    <= '0;
                    busy_seen_r <= 1'b0;
                end
                ISSUE: begin
                    ce_cnt_r <= ce_cnt_r + CE_W'(1'b1);
                    if (!ctl_ready) busy_seen_r <= 1'b1;
                end
                WAIT_BUSY: begin
                    if (to_cnt_r != TO_MAX) to_cnt_r <= to_cnt_r + TO_W'(1'b1);
                end
                RESP: begin
                    ptr_r <= (gnt_idx_r == IDX_LAST) ? '0 : gnt_idx_r + IDX_W'(1'b1);
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

    // Registered host and controller outputs, derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            ctl_ceb_r   <= 1'b1;
            ctl_web_r   <= 1'b1;
            ctl_addr_r  <= '0;
            ctl_wdata_r <= '0;
        end else begin
            req_ready_r <= grant_s ? arb_gnt_s : '0;
            rsp_valid_r <= (state_s == RESP) ? (NUM_PORTS'(1'b1) << gnt_idx_r) : '0;
            rsp_err_r   <= (state_s == RESP) && timeout_s;
            rsp_rdata_r <= ((state_s == RESP) && !timeout_s && !we_r) ? ctl_rdata : '0;
            ctl_ceb_r   <= (state_s != ISSUE);
            ctl_web_r   <= (state_s == ISSUE) ? ~we_s : 1'b1;
            if (grant_s) begin
                ctl_addr_r  <= req_addr[arb_idx_s*ADDR_W +: ADDR_W];
                ctl_wdata_r <= req_wdata[arb_idx_s*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign ctl_ceb   = ctl_ceb_r;
    assign ctl_web   = ctl_web_r;
    assign ctl_addr  = ctl_addr_r;
    assign ctl_wdata = ctl_wdata_r;

endmodule
